ctrl_decode_reg: RTL
====================

Name: ctrl_decode_reg

Overview:
- Registered, parametrised successor to the core's combinational control decoder.
- Decodes RV32I plus optional RV32M from the IF/ID instruction and registers the full control bundle into the ID/EX boundary.
- Adds valid/ready handshake, stall/flush handling, illegal-instruction detection, x0-write suppression, and a multi-cycle sequencer for MUL/DIV ops.

Parameters:
ENABLE_M, 1, 1 = decode RV32M (opcode 0110011, funct7 0000001); 0 = such encodings are illegal
MUL_CYCLES, 2, busy cycles for funct3[2]=0 M-ops (MUL/MULH/MULHSU/MULHU), >=1
DIV_CYCLES, 8, busy cycles for funct3[2]=1 M-ops (DIV/DIVU/REM/REMU), >=1

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
i_instr  in  32  instruction from IF/ID
i_valid  in  1  i_instr valid
o_ready  out  1  block can accept this cycle
i_stall  in  1  downstream hold
i_flush  in  1  kill registered bundle and any M-op in progress
o_valid  out  1  bundle valid for EX
o_rd / o_rs1 / o_rs2  out  5 each  instr[11:7] / [19:15] / [24:20]
o_reg_we  out  1  register write enable
o_alu_op  out  4  ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111, PASSB 1001
o_use_imm_b  out  1  ALU B operand = immediate
o_mem_we / o_mem_re  out  1 each  store / load
o_mem_size  out  3  0 byte, 1 half, 2 word
o_mem_unsigned  out  1  LBU/LHU
o_is_branch / o_is_jal / o_is_jalr / o_is_lui / o_is_auipc  out  1 each  instruction class
o_br_funct3  out  3  branch condition
o_br_un  out  1  unsigned compare (funct3 110/111)
o_wb_sel  out  2  00 ALU, 01 mem, 10 PC+4, 11 M-unit
o_md_op  out  3  M-op funct3
o_md_start  out  1  one-cycle M-unit start pulse
o_illegal  out  1  illegal instruction

Behaviour:
- Interface: one clock i_clk; reset i_reset is synchronous and active-high.
- Bubble value: all outputs 0, except o_mem_size=2 and o_ready=1. Reset loads the bubble and sets FSM=IDLE.
- Accept: occurs when i_valid && o_ready. o_ready = (state==IDLE) && !i_stall && !i_flush.
- Latency: decoded bundle is registered 1 cycle after accept.
- Cycle with no accept and no stall: bubble is loaded.
- Stall: i_stall=1 holds every output register, and the busy counter, unchanged.
- Flush: highest priority after reset. Loads the bubble, forces FSM to IDLE, and clears the counter in the same edge, regardless of stall.
- Decoding: per RV32I. SRAI/SRA select on funct7=0100000. LUI gives PASSB with o_is_lui. AUIPC gives ADD with o_is_auipc.
- Write-back select: JAL/JALR give o_wb_sel=10; loads give 01; M-ops give 11; all others 00.
- x0 writes: o_reg_we is forced to 0 when rd=0.
- Illegal cases (o_illegal=1, o_valid=1, o_reg_we=0, o_mem_we=0, o_mem_re=0):
  - unknown opcode
  - R-type funct7 not 0000000/0100000, or not 0000001 with ENABLE_M
  - 0100000 with funct3 other than 000/101
  - SLLI funct7 not 0
  - SRLI/SRAI funct7 not 0/0100000
  - load funct3 011/110/111
  - store funct3 >2
  - branch funct3 010/011
  - JALR funct3 not 0
- FSM, IDLE: accepting an M-op loads the bundle with o_valid=0 and o_md_start=1. Counter loads MUL_CYCLES-1 or DIV_CYCLES-1. If the loaded value is 0, go to DONE; otherwise go to BUSY.
- FSM, BUSY: o_md_start=0 and o_valid=0. Counter decrements when !i_stall. At count 0 with !i_stall, go to DONE.
- FSM, DONE: o_valid=1 for exactly one non-stalled cycle, with the bundle held. Next non-stalled edge loads the bubble and returns to IDLE. o_ready stays 0 throughout BUSY and DONE.
- An M-op occupies MUL_CYCLES+1 (or DIV_CYCLES+1) non-stalled cycles before the next accept.

Test Plan:
- Reset: i_reset=1 for 2 cycles with i_valid=1, instr 0x00500093 -> after release, o_valid=0, o_mem_size=2, o_ready=1; next cycle o_valid=1, o_reg_we=1, o_alu_op=0000, o_use_imm_b=1, o_rd=1.
- Decode sweep: 0x40B50533 (SUB) -> alu_op 1000. 0xFFF54503 (LBU) -> mem_re=1, size 0, unsigned 1, wb_sel 01. 0x00B52023 (SW) -> mem_we=1, reg_we=0. 0x00B57463 (BGEU) -> is_branch, br_un=1, br_funct3 111. 0x008000EF (JAL) -> wb_sel 10.
- x0/illegal: 0x00000013 -> reg_we=0, illegal=0. 0x0000007F -> illegal=1, o_valid=1. 0x00003003 -> illegal=1. 0x02B50533 (MUL) with ENABLE_M=0 -> illegal=1.
- M-op: DIV 0x02B54533 with DIV_CYCLES=8 -> md_start pulse next cycle, o_ready=0, o_valid=1 only on the 8th cycle after start, with wb_sel 11 and md_op 100. o_ready=1 the cycle after.
- Stall: i_stall=1 for 3 cycles mid-BUSY -> counter frozen, DONE delayed exactly 3 cycles. i_stall during a normal bundle -> outputs unchanged.
- Flush: i_flush=1 in BUSY together with i_stall=1 -> next cycle bubble, o_ready=1, no o_valid from the aborted op.

Source files
------------

// File: rtl/ctrl_decode_reg_if.sv
// Handshake and decoded-bundle signals between the IF/ID stage and the registered decoder.
// master = upstream/consumer side, slave = the decoder itself.
interface ctrl_decode_reg_if;
  logic [31:0] i_instr;
  logic        i_valid;
  logic        o_ready;
  logic        i_stall;
  logic        i_flush;
  logic        o_valid;
  logic [4:0]  o_rd;
  logic [4:0]  o_rs1;
  logic [4:0]  o_rs2;
  logic        o_reg_we;
  logic [3:0]  o_alu_op;
  logic        o_use_imm_b;
  logic        o_mem_we;
  logic        o_mem_re;
  logic [2:0]  o_mem_size;
  logic        o_mem_unsigned;
  logic        o_is_branch;
  logic        o_is_jal;
  logic        o_is_jalr;
  logic        o_is_lui;
  logic        o_is_auipc;
  logic [2:0]  o_br_funct3;
  logic        o_br_un;
  logic [1:0]  o_wb_sel;
  logic [2:0]  o_md_op;
  logic        o_md_start;
  logic        o_illegal;

  modport master (
    output i_instr, i_valid, i_stall, i_flush,
    input  o_ready, o_valid, o_rd, o_rs1, o_rs2, o_reg_we, o_alu_op, o_use_imm_b,
           o_mem_we, o_mem_re, o_mem_size, o_mem_unsigned, o_is_branch, o_is_jal,
           o_is_jalr, o_is_lui, o_is_auipc, o_br_funct3, o_br_un, o_wb_sel,
           o_md_op, o_md_start, o_illegal
  );

  modport slave (
    input  i_instr, i_valid, i_stall, i_flush,
    output o_ready, o_valid, o_rd, o_rs1, o_rs2, o_reg_we, o_alu_op, o_use_imm_b,
           o_mem_we, o_mem_re, o_mem_size, o_mem_unsigned, o_is_branch, o_is_jal,
           o_is_jalr, o_is_lui, o_is_auipc, o_br_funct3, o_br_un, o_wb_sel,
           o_md_op, o_md_start, o_illegal
  );
endinterface

// File: rtl/ctrl_decode_reg.sv
// Registered RV32I(+M) control decoder feeding the ID/EX boundary, with a
// busy sequencer that holds off new instructions while a MUL/DIV is in flight.
//
//   state | meaning
//   IDLE  | accepting instructions; bundle is a decoded op or the bubble
//   BUSY  | M-op in flight, counter running, o_valid held low
//   DONE  | M-op result presented with o_valid for one non-stalled cycle
module ctrl_decode_reg #(
  parameter bit ENABLE_M   = 1'b1,
  parameter int MUL_CYCLES = 2,
  parameter int DIV_CYCLES = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  ctrl_decode_reg_if.slave bus
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MD   = 7'b0000001;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_SLL   = 4'b0001;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SRA   = 4'b1101;
  localparam logic [3:0] ALU_PASSB = 4'b1001;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;
  localparam logic [1:0] WB_MD  = 2'b11;

  localparam int CNT_MAX = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       reg_we;
    logic [3:0] alu_op;
    logic       use_imm_b;
    logic       mem_we;
    logic       mem_re;
    logic [2:0] mem_size;
    logic       mem_unsigned;
    logic       is_branch;
    logic       is_jal;
    logic       is_jalr;
    logic       is_lui;
    logic       is_auipc;
    logic [2:0] br_funct3;
    logic       br_un;
    logic [1:0] wb_sel;
    logic [2:0] md_op;
    logic       md_start;
    logic       illegal;
  } bundle_t;

  state_t        state;
  logic [CW-1:0] cnt;
  bundle_t       q;
  bundle_t       bubble;
  bundle_t       dec;
  logic          dec_is_md;
  logic [CW-1:0] md_load;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       writes_rd;
  logic       bad;

  assign opcode = bus.i_instr[6:0];
  assign funct3 = bus.i_instr[14:12];
  assign funct7 = bus.i_instr[31:25];

  always_comb begin
    bubble          = '0;
    bubble.mem_size = 3'd2;
  end

  always_comb begin
    dec           = '0;
    dec.valid     = 1'b1;
    dec.rd        = bus.i_instr[11:7];
    dec.rs1       = bus.i_instr[19:15];
    dec.rs2       = bus.i_instr[24:20];
    dec.mem_size  = 3'd2;
    dec.alu_op    = ALU_ADD;
    dec.wb_sel    = WB_ALU;
    writes_rd     = 1'b0;
    bad           = 1'b0;
    dec_is_md     = 1'b0;

    case (opcode)
      OPC_OP: begin
        if (funct7 == F7_BASE) begin
          dec.alu_op = {1'b0, funct3};
          writes_rd  = 1'b1;
        end else if (funct7 == F7_ALT) begin
          writes_rd = 1'b1;
          if (funct3 == 3'b000)      dec.alu_op = ALU_SUB;
          else if (funct3 == 3'b101) dec.alu_op = ALU_SRA;
          else                       bad = 1'b1;
        end else if (ENABLE_M && funct7 == F7_MD) begin
          dec_is_md  = 1'b1;
          dec.md_op  = funct3;
          dec.wb_sel = WB_MD;
          writes_rd  = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        dec.use_imm_b = 1'b1;
        writes_rd     = 1'b1;
        case (funct3)
          3'b001: begin
            dec.alu_op = ALU_SLL;
            if (funct7 != F7_BASE) bad = 1'b1;
          end
          3'b101: begin
            if (funct7 == F7_BASE)     dec.alu_op = ALU_SRL;
            else if (funct7 == F7_ALT) dec.alu_op = ALU_SRA;
            else                       bad = 1'b1;
          end
          default: dec.alu_op = {1'b0, funct3};
        endcase
      end
      OPC_LOAD: begin
        if (funct3 == 3'b011 || funct3[2:1] == 2'b11) begin
          bad = 1'b1;
        end else begin
          dec.mem_re       = 1'b1;
          dec.mem_size     = {1'b0, funct3[1:0]};
          dec.mem_unsigned = funct3[2];
          dec.use_imm_b    = 1'b1;
          dec.wb_sel       = WB_MEM;
          writes_rd        = 1'b1;
        end
      end
      OPC_STORE: begin
        if (funct3 > 3'd2) begin
          bad = 1'b1;
        end else begin
          dec.mem_we    = 1'b1;
          dec.mem_size  = funct3;
          dec.use_imm_b = 1'b1;
        end
      end
      OPC_BRANCH: begin
        if (funct3[2:1] == 2'b01) begin
          bad = 1'b1;
        end else begin
          dec.is_branch = 1'b1;
          dec.br_funct3 = funct3;
          dec.br_un     = funct3[2] & funct3[1];
        end
      end
      OPC_JAL: begin
        dec.is_jal = 1'b1;
        dec.wb_sel = WB_PC4;
        writes_rd  = 1'b1;
      end
      OPC_JALR: begin
        if (funct3 != 3'b000) begin
          bad = 1'b1;
        end else begin
          dec.is_jalr   = 1'b1;
          dec.use_imm_b = 1'b1;
          dec.wb_sel    = WB_PC4;
          writes_rd     = 1'b1;
        end
      end
      OPC_LUI: begin
        dec.alu_op    = ALU_PASSB;
        dec.use_imm_b = 1'b1;
        dec.is_lui    = 1'b1;
        writes_rd     = 1'b1;
      end
      OPC_AUIPC: begin
        dec.use_imm_b = 1'b1;
        dec.is_auipc  = 1'b1;
        writes_rd     = 1'b1;
      end
      default: bad = 1'b1;
    endcase

    dec.reg_we = writes_rd && !bad && (bus.i_instr[11:7] != 5'd0);
    if (bad) begin
      dec.illegal = 1'b1;
      dec.mem_we  = 1'b0;
      dec.mem_re  = 1'b0;
      dec_is_md   = 1'b0;
    end
  end

  assign md_load = funct3[2] ? DIV_LOAD : MUL_LOAD;

  always_ff @(posedge i_clk) begin
    if (i_reset || bus.i_flush) begin
      q     <= bubble;
      state <= IDLE;
      cnt   <= '0;
    end else if (!bus.i_stall) begin
      case (state)
        IDLE: begin
          if (bus.i_valid && dec_is_md) begin
            q          <= dec;
            q.valid    <= 1'b0;
            q.md_start <= 1'b1;
            cnt        <= md_load;
            state      <= (md_load == '0) ? DONE : BUSY;
          end else if (bus.i_valid) begin
            q <= dec;
          end else begin
            q <= bubble;
          end
        end
        BUSY: begin
          q.md_start <= 1'b0;
          if (cnt == '0) begin
            q.valid <= 1'b1;
            state   <= DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DONE: begin
          // Entered straight from IDLE when the load value was 0: present first.
          if (q.valid) begin
            q     <= bubble;
            state <= IDLE;
          end else begin
            q.valid    <= 1'b1;
            q.md_start <= 1'b0;
          end
        end
        default: begin
          q     <= bubble;
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.o_ready        = (state == IDLE) && !bus.i_stall && !bus.i_flush;
  assign bus.o_valid        = q.valid;
  assign bus.o_rd           = q.rd;
  assign bus.o_rs1          = q.rs1;
  assign bus.o_rs2          = q.rs2;
  assign bus.o_reg_we       = q.reg_we;
  assign bus.o_alu_op       = q.alu_op;
  assign bus.o_use_imm_b    = q.use_imm_b;
  assign bus.o_mem_we       = q.mem_we;
  assign bus.o_mem_re       = q.mem_re;
  assign bus.o_mem_size     = q.mem_size;
  assign bus.o_mem_unsigned = q.mem_unsigned;
  assign bus.o_is_branch    = q.is_branch;
  assign bus.o_is_jal       = q.is_jal;
  assign bus.o_is_jalr      = q.is_jalr;
  assign bus.o_is_lui       = q.is_lui;
  assign bus.o_is_auipc     = q.is_auipc;
  assign bus.o_br_funct3    = q.br_funct3;
  assign bus.o_br_un        = q.br_un;
  assign bus.o_wb_sel       = q.wb_sel;
  assign bus.o_md_op        = q.md_op;
  assign bus.o_md_start     = q.md_start;
  assign bus.o_illegal      = q.illegal;

endmodule
